// File: rtl/alu_cmd_pkg.sv
// Command format shared by the run button capture stage and the ALU/register-file core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_cmd_pkg;

  localparam int OP_W   = 3;
  localparam int ADDR_W = 3;
  localparam int CMD_W  = OP_W + 3 * ADDR_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b011,
    OP_CAS = 3'b111
  } op_e;

  // Field order matches the switch bank: op in the MSBs, addr3 in the LSBs.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_REL = 2'd2
  } cap_state_e;

endpackage

// File: rtl/run_cmd_capture_debounce_sync.sv
// Synchronises and debounces a raw push-button, producing a clean level and a 0->1 pulse.
// Latency: 2 sync edges + DEBOUNCE_CYCLES edges until the level flips; rise follows the flip.
// Backpressure: none; free-running.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_BITS = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync_q1;
  logic                sync_q2;
  logic                level_q;
  logic                level_d1;
  logic [CNT_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  // The counter only runs while the synced input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q2 == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      level_q <= ~level_q;
    end else begin
      cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d1 <= 1'b0;
    end else begin
      level_d1 <= level_q;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_d1;

endmodule

// File: rtl/run_cmd_capture.sv
// Turns each debounced run press into one latched command offered to the core.
// Latency: cmd_valid 2+DEBOUNCE_CYCLES+1 edges after run is first sampled high.
// Backpressure: command held stable on cmd_valid until cmd_ready; new presses ignored while busy.
module run_cmd_capture
  import alu_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [CMD_W-1:0]  command,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [OP_W-1:0]   cmd_op,
  output logic [ADDR_W-1:0] cmd_a1,
  output logic [ADDR_W-1:0] cmd_a2,
  output logic [ADDR_W-1:0] cmd_a3,
  output logic              busy,
  output logic [CNT_W-1:0]  issue_count
);

  logic       run_level;
  logic       run_rise;
  cap_state_e state_q;
  cap_state_e state_d;
  logic       load_cmd;
  logic       handshake;
  cmd_t       cmd_q;
  logic [CNT_W-1:0] issue_count_q;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (run),
    .level (run_level),
    .rise  (run_rise)
  );

  assign handshake = (state_q == ST_ISSUE) && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_cmd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_rise) begin
          load_cmd = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A still-held button must be released before another issue is allowed.
        if (handshake) begin
          state_d = run_level ? ST_WAIT_REL : ST_IDLE;
        end
      end
      ST_WAIT_REL: begin
        if (!run_level) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Switches are quasi-static, so they are captured without synchronisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
    end else if (load_cmd) begin
      cmd_q <= cmd_t'(command);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_q <= '0;
    end else if (handshake) begin
      issue_count_q <= issue_count_q + CNT_W'(1);
    end
  end

  assign cmd_valid   = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign cmd_op      = cmd_q.op;
  assign cmd_a1      = cmd_q.a1;
  assign cmd_a2      = cmd_q.a2;
  assign cmd_a3      = cmd_q.a3;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_run_cmd_capture.sv
// Randomised scoreboard bench for run_cmd_capture with a short debounce window.
module tb_run_cmd_capture;
  import alu_cmd_pkg::*;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [11:0] command = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [2:0]  cmd_op, cmd_a1, cmd_a2, cmd_a3;
  logic        busy;
  logic [7:0]  issue_count;

  run_cmd_capture #(.DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .command(command),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a1(cmd_a1), .cmd_a2(cmd_a2), .cmd_a3(cmd_a3),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] cmd;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_count = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: a press held for at least DB synced cycles issues once; its payload is the
  // switch value at the press, and handshakes are numbered in order.
  task automatic expect_issue(input logic [11:0] c);
    sb_q.push_back('{cmd: c, cnt: exp_count});
    exp_count = exp_count + 8'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!cmd_valid && n < 40) begin
      step();
      n++;
    end
    if (!cmd_valid) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting cmd_valid got 0 want 1", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin
      if (cmd_valid) cmd_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic press(input logic [11:0] c, input int high, input int low);
    command = c;
    run = 1'b1;
    steps(high);
    run = 1'b0;
    steps(low);
  endtask

  // Monitor: compares every handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid: got cmd_valid=1 want 0 (op=%0d)", cmd_op);
      end else if (cmd_ready) begin
        mon_e = sb_q.pop_front();
        check("payload", {20'd0, cmd_op, cmd_a1, cmd_a2, cmd_a3}, {20'd0, mon_e.cmd});
        check("count_before", {24'd0, issue_count}, {24'd0, mon_e.cnt});
      end
    end
  end

  initial begin
    int n;
    logic [11:0] c;
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", issue_count, 0);
    check("rst_payload", {cmd_op, cmd_a1, cmd_a2, cmd_a3}, 0);
    steps(3);
    rst_n = 1'b1;
    steps(2);

    // Clean press with latency measurement.
    command = 12'b000_001_010_000;
    cmd_ready = 1'b1;
    expect_issue(command);
    run = 1'b1;
    n = 0;
    while (!cmd_valid && n < 30) begin
      step();
      n++;
    end
    check("latency", n, 2 + DB + 1);
    step();
    check("valid_one_cycle", cmd_valid, 0);
    check("busy_held", busy, 1);
    steps(12);
    run = 1'b0;
    steps(12);
    check("busy_released", busy, 0);
    check("count_clean", issue_count, 1);

    // Bounce then steady press: one issue.
    c = 12'h5a3;
    command = c;
    expect_issue(c);
    for (int i = 0; i < 5; i++) begin
      run = 1'b1; steps(2);
      run = 1'b0; steps(2);
    end
    press(c, 20, 12);
    check("count_bounce", issue_count, 2);

    // Short glitches: no issue.
    for (int i = 0; i < 4; i++) press(12'hfff, 3, 10);
    check("count_glitch", issue_count, 2);

    // Backpressure with release and switch change while pending.
    cmd_ready = 1'b0;
    command = 12'b111_001_010_011;
    expect_issue(command);
    run = 1'b1;
    wait_valid("bp_wait");
    run = 1'b0;
    command = 12'h000;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", cmd_valid, 1);
      check("bp_payload", {cmd_op, cmd_a1, cmd_a2, cmd_a3}, 12'b111_001_010_011);
    end
    cmd_ready = 1'b1;
    steps(2);
    check("bp_done_valid", cmd_valid, 0);
    check("bp_done_idle", busy, 0);

    // Held button: one issue, then another after release.
    expect_issue(12'h321);
    press(12'h321, 100, 12);
    expect_issue(12'h654);
    press(12'h654, 10, 12);
    check("count_held", issue_count, exp_count);

    // Reset while a command is pending.
    cmd_ready = 1'b0;
    expect_issue(12'h777);
    command = 12'h777;
    run = 1'b1;
    wait_valid("rst_wait");
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", issue_count, 0);
    check("mid_rst_payload", {cmd_op, cmd_a1, cmd_a2, cmd_a3}, 0);
    sb_q.delete();
    exp_count = '0;
    run = 1'b0;
    steps(3);
    rst_n = 1'b1;
    steps(2);

    // 256 presses wrap the counter back to zero.
    cmd_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      c = 12'($urandom);
      expect_issue(c);
      press(c, 10, 10);
    end
    check("count_wrap", issue_count, 0);

    // Random mix of glitches and presses under random readiness.
    for (int i = 0; i < 30; i++) begin
      c = 12'($urandom);
      command = c;
      if ($urandom_range(0, 2) == 0) begin
        press(c, $urandom_range(1, 3), 10);
      end else begin
        expect_issue(c);
        run = 1'b1;
        n = $urandom_range(8, 30);
        for (int k = 0; k < n; k++) begin
          cmd_ready = 1'($urandom_range(0, 1));
          step();
        end
        run = 1'b0;
        command = 12'($urandom);
        wait_idle("rand_idle");
        steps(2);
      end
    end
    cmd_ready = 1'b1;
    steps(5);
    check("rand_count", issue_count, exp_count);
    check("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
